// File: rtl/barrel_unshift_pkg.sv
// Shared definitions for barrel_unshift_seq: controller state encoding and default sizes.
// The logarithmic SHIFT option is selected by the BARREL_UNSHIFT_LOG_EN macro in the top.
package barrel_unshift_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/barrel_unshift_seq_rotr_stage.sv
// rotr_stage: one fixed right-rotate by AMT bit positions, bypassed when en_i is low.
// Purely combinational; AMT must be in 1..WIDTH-1.
module rotr_stage #(
    parameter int WIDTH = 8,
    parameter int AMT   = 1
) (
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    assign q_o = en_i ? {d_i[AMT-1:0], d_i[WIDTH-1:AMT]} : d_i;

endmodule

// File: rtl/barrel_unshift_seq.sv
// Sequential rotate-right unit: one word at a time, linear one-bit-per-cycle SHIFT by default,
// or a fixed SEL_W-cycle logarithmic SHIFT when BARREL_UNSHIFT_LOG_EN is defined.
module barrel_unshift_seq
    import barrel_unshift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] stepOut;

`ifdef BARREL_UNSHIFT_LOG_EN
    logic [SEL_W-1:0] step_q, step_d;
    logic [WIDTH-1:0] stageOut [SEL_W];

    // Stage k rotates by 2^(SEL_W-1-k) when the matching bit of the latched amount is set.
    for (genvar k = 0; k < SEL_W; k++) begin : g_stage
        rotr_stage #(
            .WIDTH(WIDTH),
            .AMT  (1 << (SEL_W - 1 - k))
        ) u_stage (
            .en_i(cnt_q[SEL_W-1-k]),
            .d_i (work_q),
            .q_o (stageOut[k])
        );
    end

    always_comb begin
        stepOut = work_q;
        for (int k = 0; k < SEL_W; k++) begin
            if (step_q == SEL_W'(k)) begin
                stepOut = stageOut[k];
            end
        end
    end
`else
    rotr_stage #(
        .WIDTH(WIDTH),
        .AMT  (1)
    ) u_stage (
        .en_i(1'b1),
        .d_i (work_q),
        .q_o (stepOut)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
`ifdef BARREL_UNSHIFT_LOG_EN
            step_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
`ifdef BARREL_UNSHIFT_LOG_EN
            step_q  <= step_d;
`endif
        end
    end

    // The work register doubles as the output, so b only moves on a load or a SHIFT step.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
`ifdef BARREL_UNSHIFT_LOG_EN
        step_d  = step_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = a;
                    cnt_d  = sel;
`ifdef BARREL_UNSHIFT_LOG_EN
                    step_d  = '0;
                    state_d = SHIFT;
`else
                    state_d = (sel != '0) ? SHIFT : HOLD;
`endif
                end
            end
            SHIFT: begin
                work_d = stepOut;
`ifdef BARREL_UNSHIFT_LOG_EN
                step_d = step_q + 1'b1;
                if (step_q == SEL_W'(SEL_W - 1)) begin
                    state_d = HOLD;
                end
`else
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SEL_W'(1)) begin
                    state_d = HOLD;
                end
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign b         = work_q;

endmodule

// File: tb/tb_barrel_unshift_seq.sv
// Self-checking bench for barrel_unshift_seq: directed cases, exhaustive round-trip and
// random transactions checked against an arithmetic rotate model (honours BARREL_UNSHIFT_LOG_EN).
module tb_barrel_unshift_seq;

    localparam int WIDTH = 8;
    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [SEL_W-1:0] sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] b;
    logic             busy;

    int assertCount = 0;
    int failCount   = 0;

    barrel_unshift_seq #(
        .WIDTH(WIDTH),
        .SEL_W(SEL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .sel      (sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .b        (b),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference: b[i] = a[(i+s) mod WIDTH], i.e. a rotate right by s.
    function automatic int rotrRef(int av, int s);
        return ((av >> s) | (av << (WIDTH - s))) & ((1 << WIDTH) - 1);
    endfunction

    function automatic int rotlRef(int av, int s);
        return ((av << s) | (av >> (WIDTH - s))) & ((1 << WIDTH) - 1);
    endfunction

    function automatic int latencyRef(int s);
`ifdef BARREL_UNSHIFT_LOG_EN
        return SEL_W + 1;
`else
        return s + 1;
`endif
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Full transaction: accept, wait for result, hold it holdCycles with out_ready low, then drain.
    task automatic applyStimulus(input int av, input int s, input int holdCycles, input int expB);
        int lat;
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = WIDTH'(av);
        sel      = SEL_W'(s);
        stepCycle();
        in_valid = 1'b0;
        a        = '0;
        sel      = '0;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            checkOutput("busy_shift", 32'({busy, in_ready}), 32'b10);
            stepCycle();
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(latencyRef(s)));
        checkOutput("result_b", 32'(b), 32'(expB));
        for (int h = 0; h < holdCycles; h++) begin
            stepCycle();
            checkOutput("hold_stable", 32'({out_valid, busy, in_ready, b}), 32'({2'b11, 1'b0, WIDTH'(expB)}));
        end
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;
        checkOutput("drain_idle", 32'({out_valid, busy, in_ready, b}), 32'({2'b00, 1'b1, WIDTH'(expB)}));
    endtask

    initial begin
        int av;
        int s;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        sel       = '0;
        out_ready = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("reset_state", 32'({out_valid, busy, b}), 32'd0);
        rst = 1'b0;
        stepCycle();
        checkOutput("post_reset_ready", 32'({in_ready, out_valid, busy}), 32'b100);

        applyStimulus(8'b01001100, 0, 0, 8'b01001100);
        applyStimulus(8'b01001100, 3, 1, 8'b10001001);
        applyStimulus(8'b01001100, 5, 0, 8'b01100010);
        applyStimulus(8'b01001100, 7, 0, 8'b10011000);

        // Result parked in HOLD while a new request waits upstream.
        in_valid = 1'b0;
        applyStimulus(8'b10110001, 2, 0, rotrRef(8'b10110001, 2));
        checkOutput("idle_before_park", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = 8'hA5;
        sel      = 3'd1;
        stepCycle();
        in_valid = 1'b0;
        for (int w = 0; w < 40 && !out_valid; w++) stepCycle();
        checkOutput("park_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        a        = 8'h3C;
        sel      = 3'd4;
        for (int h = 0; h < 5; h++) begin
            stepCycle();
            checkOutput("park_stable", 32'({out_valid, in_ready, b}), 32'({2'b10, 8'hD2}));
        end
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;
        checkOutput("park_release", 32'({out_valid, in_ready, b}), 32'({2'b01, 8'hD2}));
        stepCycle();
        in_valid = 1'b0;
        checkOutput("new_word_taken", 32'({busy, in_ready}), 32'b10);
        for (int w = 0; w < 40 && !out_valid; w++) stepCycle();
        checkOutput("new_word_result", 32'(b), 32'(rotrRef(8'h3C, 4)));
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;

        // Reset in the middle of a SHIFT must abort with nothing presented afterwards.
        in_valid = 1'b1;
        a        = 8'b01001100;
        sel      = 3'd6;
        stepCycle();
        in_valid = 1'b0;
        stepCycle();
        checkOutput("mid_shift_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("abort_state", 32'({in_ready, out_valid, busy, b}), 32'({3'b100, 8'h00}));
        for (int w = 0; w < 10; w++) begin
            stepCycle();
            checkOutput("no_stale_result", 32'({out_valid, b}), 32'd0);
        end

        // Reset wins over out_ready while holding a result.
        applyStimulus(8'hF0, 1, 0, 8'h78);
        in_valid = 1'b1;
        a        = 8'h81;
        sel      = 3'd0;
        stepCycle();
        in_valid  = 1'b0;
        for (int w = 0; w < 40 && !out_valid; w++) stepCycle();
        rst       = 1'b1;
        out_ready = 1'b1;
        stepCycle();
        rst       = 1'b0;
        out_ready = 1'b0;
        checkOutput("reset_in_hold", 32'({in_ready, out_valid, busy, b}), 32'({3'b100, 8'h00}));

        // Round-trip: rotate left in the bench, rotate right in the DUT, expect the original.
        for (int av2 = 0; av2 < 256; av2++) begin
            for (int s2 = 0; s2 < 8; s2++) begin
                applyStimulus(rotlRef(av2, s2), s2, 0, av2);
            end
        end

        for (int r = 0; r < 60; r++) begin
            av = int'($urandom_range(255, 0));
            s  = int'($urandom_range(7, 0));
            applyStimulus(av, s, int'($urandom_range(3, 0)), rotrRef(av, s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
